// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel synchronising push-button debouncer
//
// Purpose:
//   Synchronises each raw button line with two flops, then accepts a level
//   change only after the synchronised value has differed from the accepted
//   level for DEBOUNCE_CYCLES consecutive cycles. Each accepted 0->1 change
//   produces a one-cycle press_pulse. Any bounce back to the accepted level
//   restarts the count.
//
// Optional feature:
//   DEBOUNCER_RELEASE_PULSE_EN - when defined, adds the release_pulse port,
//   which pulses one cycle on each accepted 1->0 change.
//
// Ports:
//   clk            system clock
//   input_rst      synchronous active-high reset
//   buttons_raw    raw asynchronous button lines, 1 = pressed
//   btn_level      debounced (accepted) level per button
//   press_pulse    one-cycle pulse per accepted press
//   release_pulse  one-cycle pulse per accepted release (optional)

module button_debouncer #(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 input_rst,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] btn_level,
  output logic [N_BUTTONS-1:0] press_pulse
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  ,
  output logic [N_BUTTONS-1:0] release_pulse
`endif
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] sync1_q,  sync1_d;
  logic [N_BUTTONS-1:0] sync2_q,  sync2_d;
  logic [N_BUTTONS-1:0] stable_q, stable_d;
  logic [N_BUTTONS-1:0] press_q,  press_d;
  logic [CW-1:0]        cnt_q [N_BUTTONS];
  logic [CW-1:0]        cnt_d [N_BUTTONS];
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  logic [N_BUTTONS-1:0] release_q, release_d;
`endif

  always_comb begin
    sync1_d  = buttons_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press_d  = '0;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    release_d = '0;
`endif
    for (int i = 0; i < N_BUTTONS; i++) begin
      // Count is cleared whenever the synchronised line agrees with the
      // accepted level, so a bounce always restarts the stability window.
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Accept point: flip the level and fire the matching pulse in the
          // same edge so both become visible together. Count returns to 0,
          // which is why it can never wrap.
          stable_d[i] = sync2_q[i];
          press_d[i]  = sync2_q[i];
`ifdef DEBOUNCER_RELEASE_PULSE_EN
          release_d[i] = ~sync2_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (input_rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      press_q  <= '0;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
      release_q <= '0;
`endif
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = stable_q;
  assign press_pulse = press_q;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  assign release_pulse = release_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized self-checking bench for button_debouncer

module tb_button_debouncer;

  localparam int N  = 3;
  localparam int DC = 4;

  logic         clk;
  logic         input_rst;
  logic [N-1:0] buttons_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
`ifdef DEBOUNCER_RELEASE_PULSE_EN
  logic [N-1:0] release_pulse;
`endif

  int checks   = 0;
  int failures = 0;

  button_debouncer #(
    .N_BUTTONS      (N),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .input_rst  (input_rst),
    .buttons_raw(buttons_raw),
    .btn_level  (btn_level),
    .press_pulse(press_pulse)
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    ,
    .release_pulse(release_pulse)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a history of raw samples, one entry per clock edge.
  // The line seen by the debouncer at an edge is the raw sample taken two
  // edges earlier. A change is accepted when the last DC such values all
  // differ from the accepted level.
  logic [N-1:0] smp[$];
  logic [N-1:0] m_level, m_press, m_rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_step(input logic [N-1:0] raw, input logic rst);
    int sz;
    bit acc;
    if (rst) begin
      smp.delete();
      for (int k = 0; k < DC + 1; k++) smp.push_back('0);
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
    end else begin
      sz = smp.size();
      for (int ch = 0; ch < N; ch++) begin
        acc = 1'b1;
        for (int k = 1; k <= DC; k++) begin
          if (smp[sz-1-k][ch] == m_level[ch]) acc = 1'b0;
        end
        m_press[ch] = acc && !m_level[ch];
        m_rel[ch]   = acc && m_level[ch];
        if (acc) m_level[ch] = ~m_level[ch];
      end
      smp.push_back(raw);
      while (smp.size() > DC + 2) void'(smp.pop_front());
    end
  endtask

  task automatic step(input logic [N-1:0] raw, input logic rst);
    buttons_raw = raw;
    input_rst   = rst;
    @(posedge clk);
    model_step(raw, rst);
    @(negedge clk);
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("press_pulse", 32'(press_pulse), 32'(m_press));
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    chk("release_pulse", 32'(release_pulse), 32'(m_rel));
`endif
  endtask

  // Holds raw for n edges; reports the first step index at which any bit in
  // mask pulsed (press or release), the number of such pulse cycles, and the
  // first step index where btn_level & mask changed to want_level.
  task automatic hold(input logic [N-1:0] raw, input int n, input logic [N-1:0] mask,
                      input bit use_rel, input logic [N-1:0] want_level,
                      output int lat, output int cnt, output int lvl_at,
                      output logic [N-1:0] seen);
    logic [N-1:0] p;
    lat = -1; cnt = 0; lvl_at = -1; seen = '0;
    for (int j = 0; j < n; j++) begin
      step(raw, 1'b0);
`ifdef DEBOUNCER_RELEASE_PULSE_EN
      p = use_rel ? release_pulse : press_pulse;
`else
      p = use_rel ? '0 : press_pulse;
`endif
      if ((p & mask) != '0) begin
        if (lat < 0) lat = j;
        cnt++;
        seen = p;
      end
      if (lvl_at < 0 && (btn_level & mask) == want_level) lvl_at = j;
    end
  endtask

  int lat, cnt, lvl_at, pre;
  logic [N-1:0] seen;
  logic [N-1:0] cur;
  int pflip;

  initial begin
    buttons_raw = '0;
    input_rst   = 1'b1;
    step('0, 1'b1);
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_press", 32'(press_pulse), 32'd0);
    step('0, 1'b0);
    step('0, 1'b0);

    // Clean press on bit 0, then clean release.
    hold(3'b001, 10, 3'b001, 1'b0, 3'b001, lat, cnt, lvl_at, seen);
    chk("clean_lat", 32'(lat), 32'd5);
    chk("clean_cnt", 32'(cnt), 32'd1);
    chk("clean_lvl_at", 32'(lvl_at), 32'd5);
    chk("clean_only_bit0", 32'(seen), 32'b001);
`ifdef DEBOUNCER_RELEASE_PULSE_EN
    hold(3'b000, 10, 3'b001, 1'b1, 3'b000, lat, cnt, lvl_at, seen);
    chk("release_lat", 32'(lat), 32'd5);
    chk("release_cnt", 32'(cnt), 32'd1);
`else
    hold(3'b000, 10, 3'b001, 1'b0, 3'b000, lat, cnt, lvl_at, seen);
    chk("release_nopulse", 32'(cnt), 32'd0);
`endif
    chk("release_lvl_at", 32'(lvl_at), 32'd5);

    // Bounce on bit 1 then hold.
    hold(3'b010, 1, 3'b010, 1'b0, 3'b010, lat, pre, lvl_at, seen);
    hold(3'b000, 1, 3'b010, 1'b0, 3'b010, lat, cnt, lvl_at, seen); pre += cnt;
    hold(3'b010, 1, 3'b010, 1'b0, 3'b010, lat, cnt, lvl_at, seen); pre += cnt;
    hold(3'b000, 1, 3'b010, 1'b0, 3'b010, lat, cnt, lvl_at, seen); pre += cnt;
    chk("bounce_nopulse", 32'(pre), 32'd0);
    hold(3'b010, 10, 3'b010, 1'b0, 3'b010, lat, cnt, lvl_at, seen);
    chk("bounce_lat", 32'(lat), 32'd5);
    chk("bounce_cnt", 32'(cnt), 32'd1);
    hold(3'b000, 10, 3'b010, 1'b0, 3'b000, lat, cnt, lvl_at, seen);

    // Short glitch on bit 2.
    hold(3'b100, 3, 3'b100, 1'b0, 3'b100, lat, pre, lvl_at, seen);
    hold(3'b000, 10, 3'b100, 1'b0, 3'b100, lat, cnt, lvl_at, seen);
    chk("glitch_nopulse", 32'(pre + cnt), 32'd0);
    chk("glitch_level", 32'(btn_level[2]), 32'd0);

    // Simultaneous press on bits 0 and 2.
    hold(3'b101, 10, 3'b111, 1'b0, 3'b101, lat, cnt, lvl_at, seen);
    chk("simul_value", 32'(seen), 32'b101);
    chk("simul_cnt", 32'(cnt), 32'd1);
    chk("simul_lat", 32'(lat), 32'd5);
    hold(3'b000, 10, 3'b101, 1'b0, 3'b000, lat, cnt, lvl_at, seen);

    // Reset two counts into a press; button stays held afterwards.
    hold(3'b001, 4, 3'b001, 1'b0, 3'b001, lat, pre, lvl_at, seen);
    step(3'b001, 1'b1);
    chk("midrst_press", 32'(press_pulse), 32'd0);
    chk("midrst_level", 32'(btn_level), 32'd0);
    hold(3'b001, 10, 3'b001, 1'b0, 3'b001, lat, cnt, lvl_at, seen);
    chk("midrst_prepulse", 32'(pre), 32'd0);
    chk("midrst_lat", 32'(lat), 32'd5);
    chk("midrst_cnt", 32'(cnt), 32'd1);
    hold(3'b000, 10, 3'b001, 1'b0, 3'b000, lat, cnt, lvl_at, seen);

    // Randomized traffic in phases of varying bounce density.
    cur = '0;
    for (int ph = 0; ph < 6; ph++) begin
      pflip = (ph % 3 == 0) ? 2 : ((ph % 3 == 1) ? 6 : 14);
      for (int c = 0; c < 300; c++) begin
        for (int ch = 0; ch < N; ch++) begin
          if ($urandom_range(0, pflip - 1) == 0) cur[ch] = ~cur[ch];
        end
        step(cur, ($urandom_range(0, 149) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
